// File: rtl/spi_master_cfg_if.sv
// rtl/spi_master_cfg_if.sv - sequencer handshake and SPI pin bundle for spi_master_cfg
interface spi_master_cfg_if #(
   parameter int DATA_W = 8
);
   logic              spi_en;
   logic [DATA_W-1:0] spi_data;
   logic              spi_keep_cs;
   logic [DATA_W-1:0] spi_rdata;
   logic              spi_fin;
   logic              cs;
   logic              sclk;
   logic              sdo;
   logic              sdi;

   modport master (
      input  spi_en, spi_data, spi_keep_cs, sdi,
      output spi_rdata, spi_fin, cs, sclk, sdo
   );

   modport slave (
      output spi_en, spi_data, spi_keep_cs, sdi,
      input  spi_rdata, spi_fin, cs, sclk, sdo
   );
endinterface

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - parametrised SPI master with CPOL/CPHA, bit order, CS hold and bursts
module spi_master_cfg #(
   parameter int DATA_W    = 8,
   parameter int DIV       = 4,
   parameter int HOLD      = 4,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int MSB_FIRST = 1
) (
   input logic              clk_i,
   input logic              rst_i,
   spi_master_cfg_if.master bus
);
   localparam int CNT_W  = $clog2(DIV + HOLD + 1);
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((HOLD > 0) ? HOLD - 1 : 0);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
   localparam logic              IDLE_LVL  = (CPOL != 0);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                keep_q, keep_d;
   logic                cs_q, cs_d;
   logic                sclk_q, sclk_d;
   logic                sdo_q, sdo_d;
   logic                fin_q, fin_d;
   logic                lead;
   logic                last_edge;

   // Bit that goes on the wire next, taken from the end selected by bit order
   function automatic logic head_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   // Received bits enter at the far end so the first bit lands in MSB (or LSB) position
   function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
      return (MSB_FIRST != 0) ? ((w << 1) | DATA_W'(b))
                              : ((w >> 1) | (DATA_W'(b) << (DATA_W - 1)));
   endfunction

   // Edge counter holds edges already made, so the upcoming edge is odd (leading) when it is even
   assign lead      = ~edge_q[0];
   assign last_edge = (edge_q == EDGE_LAST);

   // Next-state and datapath decode for the transfer sequence
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      keep_d  = keep_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      sdo_d   = sdo_q;
      fin_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d   = bus.spi_data;
            cnt_d  = '0;
            edge_d = '0;
            if (bus.spi_en) begin
               keep_d  = bus.spi_keep_cs;
               cs_d    = 1'b0;
               state_d = S_SETUP;
               if (CPHA == 0) begin
                  sdo_d = head_bit(bus.spi_data);
                  tx_d  = tx_shift(bus.spi_data);
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               edge_d = edge_q + 1'b1;
               if (lead == (CPHA == 0)) begin
                  rx_d = rx_shift(rx_q, bus.sdi);
               end else if (!last_edge) begin
                  sdo_d = head_bit(tx_q);
                  tx_d  = tx_shift(tx_q);
               end
               if (last_edge) begin
                  sclk_d = IDLE_LVL;
                  if (HOLD > 0) begin
                     state_d = S_HOLD;
                  end else begin
                     state_d = S_DONE;
                     fin_d   = 1'b1;
                     rdata_d = rx_d;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_DONE;
               fin_d   = 1'b1;
               rdata_d = rx_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            fin_d = 1'b1;
            if (!bus.spi_en) begin
               fin_d   = 1'b0;
               state_d = S_IDLE;
               if (!keep_q) begin
                  cs_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops any partial word without touching pins mid-edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         keep_q  <= 1'b0;
         cs_q    <= 1'b1;
         sclk_q  <= IDLE_LVL;
         sdo_q   <= 1'b1;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         keep_q  <= keep_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         sdo_q   <= sdo_d;
         fin_q   <= fin_d;
      end
   end

   assign bus.cs        = cs_q;
   assign bus.sclk      = sclk_q;
   assign bus.sdo       = sdo_q;
   assign bus.spi_fin   = fin_q;
   assign bus.spi_rdata = rdata_q;
endmodule
